// File: rtl/bit_packer_pkg.sv
// Shared definitions for the serial-to-parallel bit packer: default word
// width, counter width derivation, word/count typedefs and the hold-register
// state encoding.
package bit_packer_pkg;

    localparam int WIDTH_DEF = 8;

    // Bits needed to count from 0 up to and including w ones.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W_DEF = cnt_w(WIDTH_DEF);

    typedef logic [WIDTH_DEF-1:0] word_t;
    typedef logic [CNT_W_DEF-1:0] count_t;

    // Output holding register occupancy.
    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_t;

endpackage

// File: rtl/pack_hold_reg.sv
// Single-entry output holding register for completed words.
//
// Handshake: a word moves to the consumer on a rising edge where
// out_valid (state == HOLD_FULL) and out_ready are both high. The state is
// purely registered, so out_valid never depends combinationally on
// out_ready. A word offered on load_valid is taken when the register is
// empty or is being emptied on the same edge; otherwise it is dropped and
// the sticky overflow flag is raised.
module pack_hold_reg
    import bit_packer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    localparam int CNT_W = cnt_w(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    input  logic [CNT_W-1:0] load_ones,
    input  logic             out_ready,
    input  logic             clear_overflow,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_ones,
    output logic             overflow,
    output hold_state_t      state
);

    hold_state_t state_q;
    hold_state_t state_d;
    logic        xfer;
    logic        accept;
    logic        drop;

    // Next-state and load/drop decisions for the EMPTY/FULL register.
    always_comb begin
        state_d = state_q;
        xfer    = 1'b0;
        accept  = 1'b0;
        drop    = 1'b0;

        xfer   = (state_q == HOLD_FULL) && out_ready;
        accept = load_valid && ((state_q == HOLD_EMPTY) || xfer);
        drop   = load_valid && !accept;

        if (accept) begin
            state_d = HOLD_FULL;
        end else if (xfer) begin
            state_d = HOLD_EMPTY;
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= HOLD_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Held word and its population count; only written when a word is taken,
    // so they stay stable while FULL.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_data <= '0;
            out_ones <= '0;
        end else if (accept) begin
            out_data <= load_data;
            out_ones <= load_ones;
        end
    end

    // Sticky overflow: a drop on the same edge as a clear keeps the flag set.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/bit_packer.sv
// Serial bit packer: collects in_bit on each in_valid cycle into a WIDTH-bit
// word, first bit at bit 0, with a running ones count. A word completes when
// the bit at index WIDTH-1 is accepted and is then offered to the holding
// register, which presents it with a valid/ready handshake.
module bit_packer
    import bit_packer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    localparam int CNT_W = cnt_w(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_ones,
    output logic             overflow,
    input  logic             clear_overflow
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("bit_packer: WIDTH must be in 2..32");
    end

    logic [IDX_W-1:0] bit_idx;
    logic [CNT_W-1:0] ones_run;
    logic [WIDTH-1:0] coll_data;
    logic             word_done;
    logic [WIDTH-1:0] word_next;
    logic [CNT_W-1:0] ones_next;
    hold_state_t      hold_state;

    // Completed word and count including the bit arriving this cycle.
    always_comb begin
        word_next            = coll_data;
        word_next[WIDTH-1]   = in_bit;
        ones_next            = ones_run + CNT_W'(in_bit);
        word_done            = in_valid && (bit_idx == LAST_IDX);
    end

    // Collection state: write position, partial word and running ones count.
    // Idle cycles leave everything untouched; reset discards a partial word.
    always_ff @(posedge clock) begin
        if (reset) begin
            bit_idx   <= '0;
            ones_run  <= '0;
            coll_data <= '0;
        end else if (in_valid) begin
            coll_data[bit_idx] <= in_bit;
            if (word_done) begin
                bit_idx  <= '0;
                ones_run <= '0;
            end else begin
                bit_idx  <= bit_idx + IDX_W'(1);
                ones_run <= ones_next;
            end
        end
    end

    pack_hold_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clock          (clock),
        .reset          (reset),
        .load_valid     (word_done),
        .load_data      (word_next),
        .load_ones      (ones_next),
        .out_ready      (out_ready),
        .clear_overflow (clear_overflow),
        .out_data       (out_data),
        .out_ones       (out_ones),
        .overflow       (overflow),
        .state          (hold_state)
    );

    assign out_valid = (hold_state == HOLD_FULL);

endmodule

// File: doc/bit_packer.md
BIT_PACKER -- requirements
Module: bit_packer

Interface
REQ-001 Parameter: WIDTH, 8, number of bits packed per output word (legal range 2..32).
REQ-002 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  in_bit is meaningful this cycle.
REQ-005 Port: in_bit  input  1  serial data bit, driven by the registered AND-stage output.
REQ-006 Port: out_valid  output  1  out_data and out_ones hold a completed word.
REQ-007 Port: out_ready  input  1  consumer accepts the word this cycle.
REQ-008 Port: out_data  output  WIDTH  packed word; the first bit received sits at bit 0.
REQ-009 Port: out_ones  output  CNT_W  population count of out_data; CNT_W = clog2(WIDTH+1).
REQ-010 Port: overflow  output  1  sticky flag: at least one completed word was dropped.
REQ-011 Port: clear_overflow  input  1  clears overflow.

Function
REQ-012 The block SHALL sample in_bit on every rising edge where in_valid=1 and reset=0; in_valid=0 cycles SHALL leave all collection state unchanged.
REQ-013 A bit index counter (0..WIDTH-1) SHALL select the write position, increment per accepted bit, and wrap to 0 after the bit at WIDTH-1.
REQ-014 A running ones counter SHALL increment per accepted 1 bit and restart at 0 on wrap.
REQ-015 Word complete SHALL mean a bit accepted at index WIDTH-1.
REQ-016 The output register SHALL have two states, EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017 Transfer SHALL occur on an edge where out_valid=1 and out_ready=1.
REQ-018 On word complete, if the state is EMPTY or a transfer occurs on the same edge, the word and its count (including the final bit) SHALL load and the state SHALL be FULL after that edge; the latency from the final bit's edge to out_valid is one edge.
REQ-019 On word complete while FULL with no transfer, the new word SHALL be dropped, the held word SHALL stay unchanged, and overflow SHALL be set.
REQ-020 A transfer without word complete SHALL move FULL to EMPTY.
REQ-021 While FULL, out_data and out_ones SHALL stay stable until transfer.
REQ-022 out_valid SHALL NOT depend combinationally on out_ready.
REQ-023 clear_overflow SHALL clear overflow on the next edge; when it coincides with a new drop, the set SHALL win (overflow stays 1).
REQ-024 Back-to-back words with in_valid held high SHALL be accepted without a bubble when out_ready=1.

Reset
REQ-025 Reset SHALL force out_valid=0, out_data=0, out_ones=0, overflow=0, the bit index to 0 and the running count to 0.
REQ-026 Reset mid-word SHALL discard all partial bits, and a bit presented on the reset edge SHALL NOT be accepted.
REQ-027 Reset SHALL take precedence over every other input on the same edge.

Structure
REQ-028 Package bit_packer_pkg SHALL hold the WIDTH default, the CNT_W derivation, and the typedefs for the word and count.
REQ-029 The output holding register (EMPTY/FULL, data, count, transfer logic) SHALL be one sub-module named pack_hold_reg; collection logic SHALL stay in bit_packer.
REQ-030 There SHALL be no latches and no second clock; every register SHALL be in a rising-edge block with synchronous reset.

Verification (WIDTH=8)
REQ-031 Reset 2 cycles, then bits 1,0,1,1,0,0,0,1 on consecutive cycles with out_ready=1 -> out_valid=1 one edge after the 8th bit, with out_data=0x8D and out_ones=4, for exactly 1 cycle.
REQ-032 out_ready=0; send 0xFF, then 0x00 -> out_data stays 0xFF with out_ones=8, overflow=1 after the 16th bit; then out_ready=1 -> transfer, and out_valid=0 on the next cycle.
REQ-033 in_valid toggling 1,0 over 16 cycles carrying 0xA5 -> exactly one word, 0xA5 with out_ones=4; idle cycles do not shift bits.
REQ-034 Reset asserted after 5 bits, then 8 bits of 0x3C -> out_data=0x3C with no residue from the first 5 bits.
REQ-035 Continuous stream 0x01, 0x02, 0x03 with out_ready=1 -> three transfers 8 cycles apart with no drops and overflow=0.
REQ-036 clear_overflow asserted on the same edge as a new drop -> overflow remains 1; asserting it alone on a later edge -> overflow=0.
